// File: rtl/conv3x3_stream_unit.sv
// Streaming 3x3 convolution: two line buffers plus a sliding window, four run-time kernels,
// zero-padded borders, valid/ready on both sides and a frame-done flag.
module conv3x3_stream_unit #(
  parameter int PIXEL_BIT  = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int ROW_BIT    = $clog2(IMG_HEIGHT),
  parameter int COL_BIT    = $clog2(IMG_WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baslat_i,
  input  logic [1:0]           mod_i,
  input  logic [PIXEL_BIT-1:0] veri_i,
  input  logic                 gecerli_i,
  output logic                 hazir_o,
  output logic [PIXEL_BIT-1:0] res_veri_o,
  output logic [ROW_BIT-1:0]   res_row_o,
  output logic [COL_BIT-1:0]   res_col_o,
  output logic                 res_gecerli_o,
  input  logic                 res_hazir_i,
  output logic                 res_bitti_o,
  output logic                 mesgul_o
);

  localparam int FR_BIT  = $clog2(IMG_HEIGHT + 1);
  localparam int FC_BIT  = $clog2(IMG_WIDTH + 1);
  localparam int ACC_BIT = PIXEL_BIT + 5;
  localparam logic [FR_BIT-1:0]  LAST_FR  = FR_BIT'(IMG_HEIGHT);
  localparam logic [FC_BIT-1:0]  LAST_FC  = FC_BIT'(IMG_WIDTH);
  localparam logic [ROW_BIT-1:0] LAST_ROW = ROW_BIT'(IMG_HEIGHT - 1);
  localparam logic [COL_BIT-1:0] LAST_COL = COL_BIT'(IMG_WIDTH - 1);
  localparam logic signed [ACC_BIT-1:0] PIX_MAX = ACC_BIT'((1 << PIXEL_BIT) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state_reg;
  logic [1:0]             mode_reg;
  logic [FR_BIT-1:0]      fr_reg;
  logic [FC_BIT-1:0]      fc_reg;
  logic                   feed_done_reg;
  logic [PIXEL_BIT-1:0]   lb0_reg [IMG_WIDTH+1];
  logic [PIXEL_BIT-1:0]   lb1_reg [IMG_WIDTH+1];
  logic [PIXEL_BIT-1:0]   win_reg [3][2];
  logic [PIXEL_BIT-1:0]   res_veri_reg;
  logic [ROW_BIT-1:0]     res_row_reg;
  logic [COL_BIT-1:0]     res_col_reg;
  logic                   res_gecerli_reg;
  logic                   res_bitti_reg;
  logic                   mesgul_reg;

  logic                   real_pos, produces, adv_ok, step, top_pad, left_pad;
  logic [PIXEL_BIT-1:0]   pix_in;
  logic [PIXEL_BIT-1:0]   col_new [3];
  logic signed [ACC_BIT-1:0] prod [9];
  logic signed [ACC_BIT-1:0] sum, abs_sum;
  logic [PIXEL_BIT-1:0]   result;

  function automatic logic signed [ACC_BIT-1:0] coef(input logic [1:0] mode, input int r, input int c);
    int k;
    k = 0;
    case (mode)
      2'd0:    k = (r == 1 && c == 1) ? 1 : 0;
      2'd1:    k = (c - 1) * ((r == 1) ? 2 : 1);
      2'd2:    k = (r - 1) * ((c == 1) ? 2 : 1);
      default: k = ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
    endcase
    return ACC_BIT'(k);
  endfunction

  assign real_pos = (fr_reg < LAST_FR) && (fc_reg < LAST_FC);
  assign produces = (fr_reg != '0) && (fc_reg != '0);
  assign adv_ok   = (state_reg == ST_RUN) && !feed_done_reg &&
                    (!res_gecerli_reg || res_hazir_i || !produces);
  assign hazir_o  = adv_ok && real_pos;
  assign step     = adv_ok && (!real_pos || gecerli_i);
  assign pix_in   = real_pos ? veri_i : '0;

  // Right and bottom borders arrive as injected zeros; top and left must be masked explicitly.
  assign top_pad  = (fr_reg <= FR_BIT'(1));
  assign left_pad = (fc_reg == FC_BIT'(1));
  assign col_new[0] = lb1_reg[fc_reg];
  assign col_new[1] = lb0_reg[fc_reg];
  assign col_new[2] = pix_in;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int R = gi / 3;
      localparam int C = gi % 3;
      logic [PIXEL_BIT-1:0] raw;
      logic                 tap_zero;
      if (C == 2) begin : g_new
        assign raw = col_new[R];
      end else begin : g_win
        assign raw = win_reg[R][C];
      end
      assign tap_zero = ((R == 0) && top_pad) || ((C == 0) && left_pad);
      assign prod[gi] = tap_zero ? '0 :
                        $signed({{(ACC_BIT-PIXEL_BIT){1'b0}}, raw}) * coef(mode_reg, R, C);
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + prod[i];
  end

  assign abs_sum = sum[ACC_BIT-1] ? -sum : sum;

  always_comb begin
    case (mode_reg)
      2'd0:        result = sum[PIXEL_BIT-1:0];
      2'd1, 2'd2:  result = (abs_sum > PIX_MAX) ? {PIXEL_BIT{1'b1}} : abs_sum[PIXEL_BIT-1:0];
      default:     result = sum[PIXEL_BIT+3:4];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= '0;
      fr_reg          <= '0;
      fc_reg          <= '0;
      feed_done_reg   <= 1'b0;
      for (int i = 0; i <= IMG_WIDTH; i++) begin
        lb0_reg[i] <= '0;
        lb1_reg[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= '0;
        win_reg[r][1] <= '0;
      end
      res_veri_reg    <= '0;
      res_row_reg     <= '0;
      res_col_reg     <= '0;
      res_gecerli_reg <= 1'b0;
      res_bitti_reg   <= 1'b0;
      mesgul_reg      <= 1'b0;
    end else if (state_reg != ST_RUN) begin
      if (baslat_i) begin
        state_reg     <= ST_RUN;
        mode_reg      <= mod_i;
        fr_reg        <= '0;
        fc_reg        <= '0;
        feed_done_reg <= 1'b0;
        res_bitti_reg <= 1'b0;
        mesgul_reg    <= 1'b1;
      end
    end else begin
      if (step) begin
        lb0_reg[fc_reg] <= pix_in;
        lb1_reg[fc_reg] <= lb0_reg[fc_reg];
        for (int r = 0; r < 3; r++) begin
          win_reg[r][0] <= win_reg[r][1];
          win_reg[r][1] <= col_new[r];
        end
        if (fc_reg == LAST_FC) begin
          fc_reg <= '0;
          if (fr_reg == LAST_FR) feed_done_reg <= 1'b1;
          else                   fr_reg <= fr_reg + 1'b1;
        end else begin
          fc_reg <= fc_reg + 1'b1;
        end
      end
      // Output pixel (fr-1, fc-1) is complete once its bottom-right neighbour is fed.
      if (step && produces) begin
        res_gecerli_reg <= 1'b1;
        res_veri_reg    <= result;
        res_row_reg     <= ROW_BIT'(fr_reg - 1'b1);
        res_col_reg     <= COL_BIT'(fc_reg - 1'b1);
      end else if (res_hazir_i) begin
        res_gecerli_reg <= 1'b0;
      end
      if (res_gecerli_reg && res_hazir_i && res_row_reg == LAST_ROW && res_col_reg == LAST_COL) begin
        state_reg     <= ST_DONE;
        res_bitti_reg <= 1'b1;
        mesgul_reg    <= 1'b0;
      end
    end
  end

  assign res_veri_o    = res_veri_reg;
  assign res_row_o     = res_row_reg;
  assign res_col_o     = res_col_reg;
  assign res_gecerli_o = res_gecerli_reg;
  assign res_bitti_o   = res_bitti_reg;
  assign mesgul_o      = mesgul_reg;

endmodule
